// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double dabble, one shift/correct step per clock.
// Valid/ready handshake on the operand side and on the result side.
module bcd_to_bin_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err,
  output logic                  busy
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state, state_next;
  logic [W-1:0]     bcd_reg, bin_reg;
  logic [W-1:0]     bcd_next, bin_next;
  logic [CNT_W-1:0] cnt;
  logic             bad_digit;
  logic             last_step;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    bad_digit = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_in[4*k +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right across both registers, then
  // pull every BCD digit that crossed 8 back down by 3.
  always_comb begin
    {bcd_next, bin_next} = {bcd_reg, bin_reg} >> 1;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_next[4*k +: 4] >= 4'd8) bcd_next[4*k +: 4] = bcd_next[4*k +: 4] - 4'd3;
    end
  end

  assign last_step = (cnt == LAST_STEP);
  assign in_ready  = (state == IDLE);
  assign busy      = (state == CONV);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = bad_digit ? DONE : CONV;
      CONV:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_reg   <= '0;
      bin_reg   <= '0;
      cnt       <= '0;
      bin_out   <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (bad_digit) begin
              bin_out   <= '0;
              err       <= 1'b1;
              out_valid <= 1'b1;
            end else begin
              bcd_reg <= bcd_in;
              bin_reg <= '0;
              cnt     <= '0;
            end
          end
        end
        CONV: begin
          bcd_reg <= bcd_next;
          bin_reg <= bin_next;
          cnt     <= cnt + CNT_W'(1);
          if (last_step) begin
            // Upper bits of bin_next are zero for any legal operand.
            bin_out   <= BIN_W'(bin_next);
            err       <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (DIGITS=2, BIN_W=7).
// Expected values are hand-computed decimal equivalents of the BCD operands.
module tb_bcd_to_bin_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] bcd_in;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] bin_out;
  logic       err;
  logic       busy;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] op);
    bcd_in   = op;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Call right after the acceptance edge; lat counts edges from acceptance to out_valid.
  task automatic wait_result(input string tag, input logic [6:0] exp_bin, input logic exp_err,
                             input int exp_lat);
    int lat = 0;
    int busy_cnt = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_cnt), exp_err ? 32'd0 : 32'(exp_lat));
    check({tag, "_bin"}, 32'(bin_out), 32'(exp_bin));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, "_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int t0;
    int delivered;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd_in    = 8'h00;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bin", 32'(bin_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Basic conversion with handshake
    accept(8'h42);
    check("h42_in_ready", 32'(in_ready), 32'd0);
    wait_result("h42", 7'd42, 1'b0, 8);
    release_result("h42");

    // Boundaries
    accept(8'h00); wait_result("h00", 7'd0, 1'b0, 8);  release_result("h00");
    accept(8'h99); wait_result("h99", 7'd99, 1'b0, 8); release_result("h99");
    accept(8'h10); wait_result("h10", 7'd10, 1'b0, 8); release_result("h10");

    // Invalid nibbles
    accept(8'h1A); wait_result("h1A", 7'd0, 1'b1, 0); release_result("h1A");
    accept(8'hF0); wait_result("hF0", 7'd0, 1'b1, 0); release_result("hF0");

    // Valid after error clears err
    accept(8'h07); wait_result("h07", 7'd7, 1'b0, 8); release_result("h07");

    // Backpressure with a pending upstream operand
    accept(8'h57);
    wait_result("h57", 7'd57, 1'b0, 8);
    bcd_in   = 8'h33;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_bin", 32'(bin_out), 32'd57);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_drop", 32'(out_valid), 32'd0);
    check("bp_idle", 32'(in_ready), 32'd1);
    check("bp_hold_bin", 32'(bin_out), 32'd57);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("bp_pend_busy", 32'(busy), 32'd1);
    wait_result("h33", 7'd33, 1'b0, 8);
    release_result("h33");

    // Reset in the middle of a conversion
    accept(8'h63);
    repeat (4) tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_bin", 32'(bin_out), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    tick();
    check("mid_post_valid", 32'(out_valid), 32'd0);
    accept(8'h25); wait_result("h25", 7'd25, 1'b0, 8); release_result("h25");

    // Exhaustive back-to-back sweep
    out_ready = 1'b1;
    in_valid  = 1'b1;
    delivered = 0;
    t0        = cyc;
    for (int i = 0; i < 100; i++) begin
      bcd_in = {4'(i / 10), 4'(i % 10)};
      check("sweep_ready", 32'(in_ready), 32'd1);
      tick();
      wait_result("sweep", 7'(i), 1'b0, 8);
      if (out_valid) delivered++;
      tick();
      check("sweep_drop", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    check("sweep_delivered", 32'(delivered), 32'd100);
    check("sweep_cycles", 32'(cyc - t0), 32'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
